// File: rtl/sound_timer_player.sv
// sound_timer_player: audio back end. Counts a requested duration down in
// slow ticks, pulses time_up on expiry and plays a square-wave tone chosen
// by the live sound_key while the countdown is running.
module sound_timer_player #(
    parameter int TICK_DIV   = 5_000_000,
    parameter int TONE1_HALF = 47_778,
    parameter int TONE2_HALF = 113_636,
    parameter int TONE3_HALF = 75_843
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] sound_key,
    input  logic       request_time,
    input  logic [3:0] time_amount,
    output logic       time_up,
    output logic       busy,
    output logic [3:0] remaining,
    output logic       audio_out,
    output logic       audio_en
);

    localparam int PW = $clog2(TICK_DIV);
    localparam int MAX_12 = (TONE1_HALF > TONE2_HALF) ? TONE1_HALF : TONE2_HALF;
    localparam int MAX_HALF = (MAX_12 > TONE3_HALF) ? MAX_12 : TONE3_HALF;
    localparam int TW = $clog2(MAX_HALF + 1);
    localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);
    localparam int HALF_TAB [3] = '{TONE1_HALF, TONE2_HALF, TONE3_HALF};

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t          state_reg;
    state_t          state_next;
    logic [PW-1:0]   prescaler_reg;
    logic [3:0]      remaining_reg;
    logic            time_up_reg;
    logic [TW-1:0]   tone_cnt_reg;
    logic            audio_out_reg;
    logic [3:0]      key_prev_reg;

    logic            load;
    logic            tick_wrap;
    logic            last_unit;
    logic [2:0]      key_hit;
    logic [TW-1:0]   half_last_masked [3];
    logic [TW-1:0]   tone_last;
    logic            key_valid;
    logic            key_changed;

    // A request with a zero amount is not a load at all.
    assign load      = request_time && (time_amount != 4'd0);
    assign tick_wrap = (prescaler_reg == PRE_LAST);
    assign last_unit = (remaining_reg == 4'd1);

    // Decode the live key into one-hot hits and the matching half-period - 1.
    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_tone
            assign key_hit[gi]          = (sound_key == 4'(gi + 1));
            assign half_last_masked[gi] = key_hit[gi] ? TW'(HALF_TAB[gi] - 1) : '0;
        end
    endgenerate

    assign tone_last   = half_last_masked[0] | half_last_masked[1] | half_last_masked[2];
    assign key_valid   = |key_hit;
    assign key_changed = (sound_key != key_prev_reg);

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next state: a load always (re)enters RUN; expiry returns to IDLE.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: if (load) state_next = RUN;
            RUN:  if (!load && tick_wrap && last_unit) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Outputs decoded from state; the tone is valid only while running.
    always_comb begin
        busy     = (state_reg == RUN);
        audio_en = (state_reg == RUN) && key_valid;
    end

    // Countdown datapath: prescaler, remaining units and the expiry pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            prescaler_reg <= '0;
            remaining_reg <= 4'd0;
            time_up_reg   <= 1'b0;
        end else begin
            time_up_reg <= 1'b0;
            if (load) begin
                // A load beats a simultaneous expiry: no pulse is issued.
                remaining_reg <= time_amount;
                prescaler_reg <= '0;
            end else if (state_reg == RUN) begin
                if (tick_wrap) begin
                    prescaler_reg <= '0;
                    remaining_reg <= remaining_reg - 4'd1;
                    time_up_reg   <= last_unit;
                end else begin
                    prescaler_reg <= prescaler_reg + PW'(1);
                end
            end
        end
    end

    // Tone generator: restarts whenever the key changes so every tone begins low.
    always_ff @(posedge clk) begin
        if (reset) begin
            tone_cnt_reg  <= '0;
            audio_out_reg <= 1'b0;
            key_prev_reg  <= 4'd0;
        end else begin
            key_prev_reg <= sound_key;
            if (!audio_en || key_changed) begin
                tone_cnt_reg  <= '0;
                audio_out_reg <= 1'b0;
            end else if (tone_cnt_reg == tone_last) begin
                tone_cnt_reg  <= '0;
                audio_out_reg <= ~audio_out_reg;
            end else begin
                tone_cnt_reg <= tone_cnt_reg + TW'(1);
            end
        end
    end

    assign remaining = remaining_reg;
    assign time_up   = time_up_reg;
    assign audio_out = audio_out_reg;

endmodule

// File: tb/tb_sound_timer_player.sv
// Testbench for sound_timer_player: directed scenarios followed by random
// stimulus, every cycle compared against a deadline-based reference model.
module tb_sound_timer_player;

    localparam int TICK = 4;
    localparam int H1   = 3;
    localparam int H2   = 5;
    localparam int H3   = 7;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] sound_key = 4'd0;
    logic       request_time = 1'b0;
    logic [3:0] time_amount = 4'd0;
    logic       time_up;
    logic       busy;
    logic [3:0] remaining;
    logic       audio_out;
    logic       audio_en;

    always #5 clk = ~clk;

    sound_timer_player #(
        .TICK_DIV   (TICK),
        .TONE1_HALF (H1),
        .TONE2_HALF (H2),
        .TONE3_HALF (H3)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .sound_key    (sound_key),
        .request_time (request_time),
        .time_amount  (time_amount),
        .time_up      (time_up),
        .busy         (busy),
        .remaining    (remaining),
        .audio_out    (audio_out),
        .audio_en     (audio_en)
    );

    int tests_run    = 0;
    int tests_failed = 0;
    int edge_cnt     = 0;

    // Reference model: the timer is an absolute deadline edge; the tone is a
    // count of uninterrupted counting edges since the last restart.
    bit busy_m     = 0;
    int expire_m   = 0;
    bit time_up_m  = 0;
    int key_prev_m = 0;
    int run_m      = 0;
    bit out_m      = 0;

    task automatic check(input string tag, input int got, input int exp);
        tests_run++;
        if (got != exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)", tag, got, exp, edge_cnt);
        end
    endtask

    function automatic int half_of(input int k);
        case (k)
            1: return H1;
            2: return H2;
            3: return H3;
            default: return 0;
        endcase
    endfunction

    task automatic model_edge(input bit r, input bit q, input int a, input int k);
        bit en;
        edge_cnt++;
        if (r) begin
            busy_m = 0; expire_m = 0; time_up_m = 0;
            key_prev_m = 0; run_m = 0; out_m = 0;
        end else begin
            en = busy_m && (half_of(k) != 0);
            if (!en || k != key_prev_m) run_m = 0;
            else run_m++;
            out_m = en && (k == key_prev_m) && (((run_m / half_of(k)) % 2) == 1);
            key_prev_m = k;
            time_up_m = 0;
            if (q && a != 0) begin
                expire_m = edge_cnt + a * TICK;
                busy_m   = 1;
            end else if (busy_m && edge_cnt == expire_m) begin
                busy_m    = 0;
                time_up_m = 1;
            end
        end
    endtask

    task automatic step(input bit r, input bit q, input int a, input int k);
        int rem_exp;
        reset        = r;
        request_time = q;
        time_amount  = 4'(a);
        sound_key    = 4'(k);
        @(posedge clk);
        model_edge(r, q, a, k);
        @(negedge clk);
        rem_exp = busy_m ? (expire_m - edge_cnt + TICK - 1) / TICK : 0;
        $display("[TB] edge %0d rst=%0d req=%0d amt=%0d key=%0d -> busy=%0d rem=%0d tu=%0d aud=%0d en=%0d",
                 edge_cnt, r, q, a, k, busy, remaining, time_up, audio_out, audio_en);
        check("busy", int'(busy), int'(busy_m));
        check("remaining", int'(remaining), rem_exp);
        check("time_up", int'(time_up), int'(time_up_m));
        check("audio_out", int'(audio_out), int'(out_m));
        check("audio_en", int'(audio_en), int'(busy_m && half_of(k) != 0));
    endtask

    task automatic idle(input int n, input int k);
        for (int i = 0; i < n; i++) step(0, 0, 0, k);
    endtask

    int keys [6] = '{0, 1, 2, 3, 15, 5};

    initial begin
        // Reset held three cycles with a request that must be ignored.
        for (int i = 0; i < 3; i++) step(1, 1, 5, 1);
        // Basic run of 5 units with tone 1.
        step(0, 1, 5, 1);
        idle(24, 1);
        // Retrigger with amount 2 six cycles after the load.
        step(0, 1, 5, 1);
        idle(5, 1);
        step(0, 1, 2, 1);
        idle(12, 1);
        // Zero-amount requests are ignored; a load on the expiry edge wins.
        step(0, 1, 0, 1);
        step(0, 1, 0, 1);
        step(0, 1, 1, 1);
        idle(3, 1);
        step(0, 1, 3, 1);
        idle(16, 1);
        // Key behaviour while running: silence, then 1 -> 3.
        step(0, 1, 8, 1);
        idle(4, 1);
        idle(3, 15);
        idle(4, 1);
        idle(20, 3);
        idle(10, 0);
        // Reset in the middle of a run.
        step(0, 1, 3, 2);
        idle(4, 2);
        step(1, 0, 0, 2);
        idle(20, 2);
        // Random traffic.
        begin
            int k;
            k = 1;
            for (int i = 0; i < 3000; i++) begin
                bit r;
                bit q;
                int a;
                r = ($urandom_range(0, 199) == 0);
                q = ($urandom_range(0, 11) == 0);
                a = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 15) : $urandom_range(0, 4);
                if ($urandom_range(0, 14) == 0) k = keys[$urandom_range(0, 5)];
                step(r, q, a, k);
            end
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/sound_timer_player.md
Name: sound_timer_player

Overview:
- Back end of the game audio path. It consumes the sound request interface (sound_key, request_time, time_amount) driven by the audio modulator FSM.
- It runs the requested sound duration as a countdown of slow ticks. On expiry it returns a one-cycle time_up pulse, which feeds the FSM's slowClk input.
- While the timer runs, it generates a square-wave tone selected by the live sound_key for the audio output stage.

Parameters:
- TICK_DIV, 5_000_000, clk cycles per time unit (100 ms at 50 MHz); must be >= 2.
- TONE1_HALF, 47_778, half-period in clk cycles for key 1 (shot).
- TONE2_HALF, 113_636, half-period for key 2 (player hit).
- TONE3_HALF, 75_843, half-period for key 3 (enemy dead).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- sound_key  in  4  tone select; 1/2/3 = tones, any other value (incl. 15) = silence
- request_time  in  1  load/restart request, sampled every clk edge
- time_amount  in  4  duration in time units, sampled with request_time
- time_up  out  1  one-cycle pulse on timer expiry (to FSM slowClk)
- busy  out  1  timer running
- remaining  out  4  time units left
- audio_out  out  1  square-wave tone
- audio_en  out  1  tone valid (busy and sound_key in 1..3)

Behaviour:
- Clocking and reset:
  - All state updates on posedge clk.
  - reset=1 at an edge gives: state=IDLE, busy=0, remaining=0, prescaler=0, time_up=0, tone counter=0, audio_out=0.
  - audio_en is combinational and therefore 0 while busy=0.
  - Reset mid-play aborts immediately with no time_up.
- States:
  - IDLE (busy=0) and RUN (busy=1). busy is the registered state bit.
- Load:
  - At any edge with request_time=1 and time_amount!=0, in either state: remaining<=time_amount, prescaler<=0, state<=RUN, time_up<=0.
  - request_time=1 with time_amount=0 is ignored. The current state continues unchanged.
- Countdown (RUN, no load):
  - prescaler counts 0..TICK_DIV-1 and wraps. Its width is $clog2(TICK_DIV).
  - At the wrap edge, remaining decrements.
  - If remaining==1 at the wrap edge: remaining<=0, state<=IDLE, time_up<=1.
- Latency: a load at edge N with amount A gives time_up high exactly in the cycle after edge N+A*TICK_DIV, for one cycle.
- time_up:
  - Default 0 every cycle. It is never asserted in IDLE.
  - Request on the expiry edge: the load wins. The timer restarts with the new amount and no time_up is issued.
- Tone generator:
  - The half-period is selected combinationally from the live sound_key. Key is not latched, because the FSM changes the key with its state.
  - When audio_en=1: tone counter counts 0..HALF-1. At HALF-1 it wraps and audio_out toggles.
  - When audio_en=0: tone counter<=0, audio_out<=0.
  - A change of sound_key between two valid keys restarts the tone counter at 0 and forces audio_out<=0 on that edge. This requires a registered copy of the previous key.
  - Tone counter width is sized for the largest HALF.
- remaining and busy are registered outputs. audio_en is combinational from busy and sound_key.

Test Plan:
Bench parameters: TICK_DIV=4, TONE1_HALF=3, TONE2_HALF=5, TONE3_HALF=7.
1. Reset: hold reset 3 cycles -> busy=0, remaining=0, time_up=0, audio_out=0, audio_en=0; request_time ignored while reset=1.
2. Basic run: sound_key=1, one-cycle request with time_amount=5 at edge N:
   - busy=1 and remaining=5 after edge N;
   - remaining decrements every 4 cycles;
   - time_up high for exactly one cycle after edge N+20, busy=0 at the same time;
   - audio_out toggles every 3 cycles while busy.
3. Retrigger: amount 5; then at 6 cycles after load, request amount 2 -> remaining=2, time_up one cycle after retrigger edge+8, with no intermediate pulse.
4. Ignored and collision requests:
   - request with time_amount=0 in IDLE -> busy stays 0;
   - request amount 3 on the exact expiry edge -> no time_up, remaining=3, time_up 12 cycles later.
5. Key behaviour while busy:
   - sound_key=15 -> audio_en=0 and audio_out=0 next edge;
   - switch key 1->3 -> audio_out forced 0, then toggles every 7 cycles.
6. Reset mid-run at remaining=2 -> next edge busy=0, remaining=0, audio_out=0, and no time_up ever follows.
